// File: rtl/iter_alu_if.sv
// Request/result bundle between a control unit and iter_alu.
//   master: control unit; drives alu_operation, alu_op1, alu_op2, alu_req
//           and receives alu_done, alu_res, alu_carry, alu_zero, alu_busy.
//   slave : the ALU; the opposite directions.
interface iter_alu_if #(
    parameter int unsigned REG_SIZE = 8
);
    logic [1:0]          alu_operation;
    logic [REG_SIZE-1:0] alu_op1;
    logic [REG_SIZE-1:0] alu_op2;
    logic                alu_req;
    logic                alu_done;
    logic [REG_SIZE-1:0] alu_res;
    logic                alu_carry;
    logic                alu_zero;
    logic                alu_busy;

    modport master (
        output alu_operation, alu_op1, alu_op2, alu_req,
        input  alu_done, alu_res, alu_carry, alu_zero, alu_busy
    );

    modport slave (
        input  alu_operation, alu_op1, alu_op2, alu_req,
        output alu_done, alu_res, alu_carry, alu_zero, alu_busy
    );
endinterface

// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle ADD/SUB/AND, REG_SIZE-cycle shift-add MUL.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-low reset
//   bus : iter_alu_if slave modport (opcode/operands/request in,
//         done pulse, result, carry, zero and busy out; all registered)
module iter_alu #(
    parameter int unsigned REG_SIZE = 8
) (
    input logic        clk,
    input logic        rst,
    iter_alu_if.slave  bus
);
    localparam int unsigned W     = REG_SIZE;
    localparam int unsigned ACC_W = 2 * REG_SIZE;
    localparam int unsigned CNT_W = $clog2(REG_SIZE);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [W-1:0]       op1_q, op1_d;
    logic [W-1:0]       op2_q, op2_d;      // also the multiplier, shifted right during MUL
    logic [ACC_W-1:0]   mcand_q, mcand_d;  // multiplicand, shifted left during MUL
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       res_q, res_d;
    logic               carry_q, carry_d;
    logic               zero_q, zero_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic [W:0]         sum;
    logic [W:0]         diff;
    logic [ACC_W-1:0]   mul_acc;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state, datapath and output logic
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        carry_d = carry_q;
        zero_d  = zero_q;

        sum     = {1'b0, op1_q} + {1'b0, op2_q};
        diff    = {1'b0, op1_q} - {1'b0, op2_q};
        mul_acc = acc_q + (op2_q[0] ? mcand_q : '0);

        unique case (state_q)
            IDLE: begin
                if (bus.alu_req) begin
                    op_d    = bus.alu_operation;
                    op1_d   = bus.alu_op1;
                    op2_d   = bus.alu_op2;
                    mcand_d = ACC_W'(bus.alu_op1);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (op_q == OP_MUL) begin
                    // One multiplier bit per cycle, LSB first; always REG_SIZE cycles
                    acc_d   = mul_acc;
                    mcand_d = mcand_q << 1;
                    op2_d   = op2_q >> 1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(REG_SIZE - 1)) begin
                        res_d   = mul_acc[W-1:0];
                        carry_d = |mul_acc[ACC_W-1:W];
                        zero_d  = (mul_acc[W-1:0] == '0);
                        state_d = DONE;
                    end
                end else begin
                    unique case (op_q)
                        OP_ADD: begin
                            res_d   = sum[W-1:0];
                            carry_d = sum[W];
                        end
                        OP_SUB: begin
                            // Borrow out of the widened subtraction == op1 < op2
                            res_d   = diff[W-1:0];
                            carry_d = diff[W];
                        end
                        default: begin
                            res_d   = op1_q & op2_q;
                            carry_d = 1'b0;
                        end
                    endcase
                    zero_d  = (res_d == '0);
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    assign bus.alu_done  = done_q;
    assign bus.alu_busy  = busy_q;
    assign bus.alu_res   = res_q;
    assign bus.alu_carry = carry_q;
    assign bus.alu_zero  = zero_q;
endmodule
